// File: rtl/vga_bar_renderer.sv
// VGA timing generator with a configurable stack of horizontal colour bars.
// Two pipeline stages (hit test, colour select) sit behind the counters, and
// every output is delayed through both so syncs and pixels stay aligned.
module vga_bar_renderer #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_POL    = 1'b0,
  parameter int unsigned NUM_BARS    = 3,
  parameter int unsigned BAR_HEIGHT  = 30,
  parameter int unsigned COLOUR_BITS = 3,
  parameter int unsigned POS_BITS    = 10
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst_L,
  input  logic [NUM_BARS*POS_BITS-1:0]        i_Bar_YPos,
  input  logic [NUM_BARS*3*COLOUR_BITS-1:0]   i_Bar_Colour,
  input  logic [NUM_BARS-1:0]                 i_Bar_Enable,
  input  logic [3*COLOUR_BITS-1:0]            i_Bg_Colour,
  output logic                                o_HSync,
  output logic                                o_VSync,
  output logic [COLOUR_BITS-1:0]              o_Red,
  output logic [COLOUR_BITS-1:0]              o_Green,
  output logic [COLOUR_BITS-1:0]              o_Blue,
  output logic                                o_Active,
  output logic                                o_Frame_Start,
  output logic [POS_BITS-1:0]                 o_X,
  output logic [POS_BITS-1:0]                 o_Y
);

  localparam int unsigned ColW   = 3 * COLOUR_BITS;
  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries are one bit wider than the counters so a zero back porch cannot overflow.
  localparam logic [POS_BITS:0] HLast     = (POS_BITS+1)'(HTotal - 1);
  localparam logic [POS_BITS:0] VLast     = (POS_BITS+1)'(VTotal - 1);
  localparam logic [POS_BITS:0] HAct      = (POS_BITS+1)'(H_ACTIVE);
  localparam logic [POS_BITS:0] VAct      = (POS_BITS+1)'(V_ACTIVE);
  localparam logic [POS_BITS:0] HSyncBeg  = (POS_BITS+1)'(H_ACTIVE + H_FRONT);
  localparam logic [POS_BITS:0] HSyncEnd  = (POS_BITS+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [POS_BITS:0] VSyncBeg  = (POS_BITS+1)'(V_ACTIVE + V_FRONT);
  localparam logic [POS_BITS:0] VSyncEnd  = (POS_BITS+1)'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [POS_BITS:0] BarH      = (POS_BITS+1)'(BAR_HEIGHT);

  logic [POS_BITS-1:0] h_q, h_d, v_q, v_d;
  logic [POS_BITS:0]   h_ext, v_ext, pos_ext;
  logic                h_wrap, frame_end;
  logic                hs0, vs0, act0, fs0;

  logic [NUM_BARS*POS_BITS-1:0] sh_pos_q;
  logic [NUM_BARS*ColW-1:0]     sh_col_q;
  logic [NUM_BARS-1:0]          sh_en_q;

  logic [NUM_BARS-1:0] hit_d, s1_hit_q;
  logic                s1_hs_q, s1_vs_q, s1_act_q, s1_fs_q;
  logic [POS_BITS-1:0] s1_x_q, s1_y_q;

  logic [ColW-1:0]     rgb_d, rgb_q;
  logic                s2_hs_q, s2_vs_q, s2_act_q, s2_fs_q;
  logic [POS_BITS-1:0] s2_x_q, s2_y_q;

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  // Stage 0: next counter values and per-pixel timing decode.
  always_comb begin
    h_wrap    = (h_ext == HLast);
    frame_end = h_wrap && (v_ext == VLast);
    h_d       = h_wrap ? '0 : h_q + 1'b1;
    v_d       = v_q;
    if (h_wrap) begin
      v_d = (v_ext == VLast) ? '0 : v_q + 1'b1;
    end
    hs0  = (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
    vs0  = (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);
    act0 = (h_ext < HAct) && (v_ext < VAct);
    fs0  = (h_q == '0) && (v_q == '0);
  end

  // Counter state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Bar settings are latched only on the last pixel of a frame, so a frame never tears.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sh_pos_q <= '0;
      sh_col_q <= '0;
      sh_en_q  <= '0;
    end else if (frame_end) begin
      sh_pos_q <= i_Bar_YPos;
      sh_col_q <= i_Bar_Colour;
      sh_en_q  <= i_Bar_Enable;
    end
  end

  // Stage 1 combinational: per-bar vertical hit test, widened so pos + height never wraps.
  always_comb begin
    hit_d   = '0;
    pos_ext = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      pos_ext  = {1'b0, sh_pos_q[k*POS_BITS +: POS_BITS]};
      hit_d[k] = sh_en_q[k] && (v_ext >= pos_ext) && (v_ext < pos_ext + BarH);
    end
  end

  // Stage 1 register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s1_hit_q <= '0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_act_q <= 1'b0;
      s1_fs_q  <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
    end else begin
      s1_hit_q <= hit_d;
      s1_hs_q  <= hs0;
      s1_vs_q  <= vs0;
      s1_act_q <= act0;
      s1_fs_q  <= fs0;
      s1_x_q   <= h_q;
      s1_y_q   <= v_q;
    end
  end

  // Stage 2 combinational: black in blanking, else lowest-index hit bar, else background.
  always_comb begin
    rgb_d = '0;
    if (s1_act_q) begin
      rgb_d = i_Bg_Colour;
      for (int k = NUM_BARS - 1; k >= 0; k--) begin
        if (s1_hit_q[k]) begin
          rgb_d = sh_col_q[k*ColW +: ColW];
        end
      end
    end
  end

  // Stage 2 register feeding the pins.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rgb_q    <= '0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s2_act_q <= 1'b0;
      s2_fs_q  <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
    end else begin
      rgb_q    <= rgb_d;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_act_q <= s1_act_q;
      s2_fs_q  <= s1_fs_q;
      s2_x_q   <= s1_x_q;
      s2_y_q   <= s1_y_q;
    end
  end

  // Sync flags hold "asserted"; polarity is applied at the pin so reset reads as deasserted.
  assign o_HSync       = s2_hs_q ? SYNC_POL : ~SYNC_POL;
  assign o_VSync       = s2_vs_q ? SYNC_POL : ~SYNC_POL;
  assign o_Red         = rgb_q[ColW-1 -: COLOUR_BITS];
  assign o_Green       = rgb_q[2*COLOUR_BITS-1 -: COLOUR_BITS];
  assign o_Blue        = rgb_q[COLOUR_BITS-1:0];
  assign o_Active      = s2_act_q;
  assign o_Frame_Start = s2_fs_q;
  assign o_X           = s2_x_q;
  assign o_Y           = s2_y_q;

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Bench for vga_bar_renderer: a time-indexed reference model checks every output
// on every clock, plus a table of bar-placement probes and directed sequences.
module tb_vga_bar_renderer;

  localparam int HA = 12, HF = 2, HS = 3, HB = 2;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int NB = 3, BH = 4, PB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [8:0] C0 = 9'o740, C1 = 9'o337, C2 = 9'o071, BG = 9'o112;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [17:0] ypos;
  logic [26:0] bcol;
  logic [2:0]  ben;
  logic [8:0]  bg;
  logic        hs, vs, act, fs;
  logic [2:0]  r, g, b;
  logic [5:0]  ox, oy;
  logic        s_hs, s_vs, s_act, s_fs;
  logic [2:0]  s_r, s_g, s_b;
  logic [3:0]  s_x, s_y;

  always #5 clk = ~clk;

  vga_bar_renderer #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .NUM_BARS(NB), .BAR_HEIGHT(BH), .COLOUR_BITS(3), .POS_BITS(PB)
  ) u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Bar_YPos(ypos), .i_Bar_Colour(bcol),
    .i_Bar_Enable(ben), .i_Bg_Colour(bg), .o_HSync(hs), .o_VSync(vs),
    .o_Red(r), .o_Green(g), .o_Blue(b), .o_Active(act), .o_Frame_Start(fs),
    .o_X(ox), .o_Y(oy)
  );

  // Minimal timing: 14 x 7 = 98-clock frame.
  vga_bar_renderer #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .NUM_BARS(1), .BAR_HEIGHT(1), .COLOUR_BITS(3), .POS_BITS(4)
  ) u_small (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Bar_YPos(4'd0), .i_Bar_Colour(9'd0),
    .i_Bar_Enable(1'b0), .i_Bg_Colour(9'o777), .o_HSync(s_hs), .o_VSync(s_vs),
    .o_Red(s_r), .o_Green(s_g), .o_Blue(s_b), .o_Active(s_act), .o_Frame_Start(s_fs),
    .o_X(s_x), .o_Y(s_y)
  );

  typedef struct packed {
    logic [17:0] pos;
    logic [2:0]  en;
    logic [26:0] col;
  } cfg_t;

  typedef struct {
    logic [17:0] pos;
    logic [2:0]  en;
    int          y;
    logic [8:0]  e;
  } vec_t;

  cfg_t       cfg [64];   // bar settings in force for each output frame (index mod 64)
  vec_t       tbl [15];
  int         n;          // clock edges since reset release
  int         vec_cnt, err_cnt;
  logic [8:0] bg_now;

  // Expected outputs after nn edges: pixel index nn-2 in raster order, bars from that frame's cfg.
  function automatic logic [24:0] model_out(int nn, logic [8:0] bgc);
    int p, x, y, f, pk;
    logic hsa, vsa, a, found;
    logic [8:0] rgb;
    cfg_t c;
    if (nn < 2) return {1'b1, 1'b1, 9'd0, 1'b0, 1'b0, 6'd0, 6'd0};
    p = nn - 2;
    x = p % HT;
    y = (p / HT) % VT;
    f = p / FT;
    c = cfg[f % 64];
    a   = (x < HA) && (y < VA);
    hsa = (x >= HA + HF) && (x < HA + HF + HS);
    vsa = (y >= VA + VF) && (y < VA + VF + VS);
    rgb = 9'd0;
    found = 1'b0;
    if (a) begin
      rgb = bgc;
      for (int k = 0; k < NB; k++) begin
        pk = int'(c.pos[k*PB +: PB]);
        if (!found && c.en[k] && y >= pk && y < pk + BH) begin
          rgb = c.col[k*9 +: 9];
          found = 1'b1;
        end
      end
    end
    return {~hsa, ~vsa, rgb, a, (p % FT) == 0, 6'(x), 6'(y)};
  endfunction

  task automatic step();
    logic [24:0] exp_v, got_v;
    if (n % FT == FT - 1) cfg[((n + 1) / FT) % 64] = {ypos, ben, bcol};
    bg_now = bg;
    @(posedge clk);
    n++;
    #1;
    exp_v = model_out(n, bg_now);
    got_v = {hs, vs, r, g, b, act, fs, ox, oy};
    vec_cnt++;
    if (got_v !== exp_v) begin
      err_cnt++;
      $display("FAIL pixel n=%0d got=%h exp=%h", n, got_v, exp_v);
    end
  endtask

  task automatic run_to(int tf, int tx, int ty);
    int t;
    t = tf * FT + ty * HT + tx + 2;
    while (n < t) step();
  endtask

  task automatic chk_val(string nm, int got, int e);
    vec_cnt++;
    if (got != e) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, e);
    end
  endtask

  task automatic chk_rgb(string nm, logic [8:0] e);
    vec_cnt++;
    if ({r, g, b} !== e) begin
      err_cnt++;
      $display("FAIL %s y=%0d got=%o exp=%o", nm, oy, {r, g, b}, e);
    end
  endtask

  // Asserts reset between clock edges, checks outputs asynchronously, then restarts the model.
  task automatic do_reset();
    int cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("reset_out", int'({hs, vs, r, g, b, act, fs, ox, oy}), 32'h180_0000);
    chk_val("small_reset_out", int'({s_hs, s_vs, s_r, s_g, s_b, s_act, s_fs, s_x, s_y}),
            32'h18_0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 64; i++) cfg[i] = '0;
    step();
    chk_val("small_fs_n1", int'(s_fs), 0);
    step();
    chk_val("small_fs_n2", int'({s_fs, s_x, s_y, s_r}), 2055);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!s_fs && cnt < 300);
    chk_val("small_fs_period", cnt, 98);
  endtask

  initial begin
    int cnt, tf;
    vec_cnt = 0;
    err_cnt = 0;
    n = 0;
    ypos = '0;
    ben  = '0;
    bcol = {C2, C1, C0};
    bg   = BG;
    for (int i = 0; i < 64; i++) cfg[i] = '0;

    tbl[0]  = '{pos: {6'd0, 6'd0, 6'd5},   en: 3'b001, y: 5,  e: C0};
    tbl[1]  = '{pos: {6'd0, 6'd0, 6'd5},   en: 3'b001, y: 8,  e: C0};
    tbl[2]  = '{pos: {6'd0, 6'd0, 6'd5},   en: 3'b001, y: 9,  e: BG};
    tbl[3]  = '{pos: {6'd0, 6'd0, 6'd5},   en: 3'b001, y: 4,  e: BG};
    tbl[4]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b011, y: 12, e: C0};
    tbl[5]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b011, y: 14, e: C1};
    tbl[6]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b011, y: 15, e: C1};
    tbl[7]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b011, y: 16, e: BG};
    tbl[8]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b010, y: 11, e: BG};
    tbl[9]  = '{pos: {6'd0, 6'd12, 6'd10}, en: 3'b010, y: 12, e: C1};
    tbl[10] = '{pos: {6'd0, 6'd0, 6'd18},  en: 3'b001, y: 19, e: C0};
    tbl[11] = '{pos: {6'd0, 6'd0, 6'd18},  en: 3'b001, y: 1,  e: BG};
    tbl[12] = '{pos: {6'd0, 6'd0, 6'd18},  en: 3'b001, y: 21, e: 9'd0};
    tbl[13] = '{pos: {6'd0, 6'd0, 6'd0},   en: 3'b100, y: 0,  e: C2};
    tbl[14] = '{pos: {6'd0, 6'd0, 6'd2},   en: 3'b101, y: 3,  e: C0};

    do_reset();

    // Main frame period, measured between two o_Frame_Start pulses.
    run_to(1, 0, 0);
    chk_val("main_fs_frame1", int'(fs), 1);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!fs && cnt < 2 * FT);
    chk_val("main_fs_period", cnt, FT);

    for (int i = 0; i < 15; i++) begin
      ypos = tbl[i].pos;
      ben  = tbl[i].en;
      tf = n / FT + 1;
      run_to(tf, 3, tbl[i].y);
      chk_rgb($sformatf("table_%0d", i), tbl[i].e);
    end

    // Position change mid-frame takes effect only in the following frame.
    ypos = {12'd0, 6'd5};
    ben  = 3'b001;
    tf = n / FT + 1;
    run_to(tf, 3, 5);
    chk_rgb("tear_old_pos", C0);
    run_to(tf, 0, 10);
    ypos = {12'd0, 6'd14};
    run_to(tf, 3, 14);
    chk_rgb("tear_new_pos_early", BG);
    run_to(tf + 1, 3, 5);
    chk_rgb("tear_old_pos_gone", BG);
    run_to(tf + 1, 3, 14);
    chk_rgb("tear_new_pos", C0);

    // Random settings changed at random moments, checked by the model every clock.
    for (int i = 0; i < 20 * FT + 137; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        ypos = {6'($urandom_range(0, 26)), 6'($urandom_range(0, 26)), 6'($urandom_range(0, 26))};
        ben  = 3'($urandom);
        bcol = 27'($urandom);
        bg   = 9'($urandom);
      end
      step();
    end

    // Reset mid-line, then more random traffic from a clean start.
    do_reset();
    for (int i = 0; i < 3 * FT; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        ypos = {6'($urandom_range(0, 26)), 6'($urandom_range(0, 26)), 6'($urandom_range(0, 26))};
        ben  = 3'($urandom);
        bcol = 27'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
